aes128_encrypt_top: RTL and testbench
=====================================

AES128_ENCRYPT_TOP -- requirements
Module: aes128_encrypt_top

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed for AES-128.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 key_0 / key_1 / key_2 / key_3  input  32 each  cipher key.
- Concatenation {key_3,key_2,key_1,key_0} forms the 128-bit key K.
REQ-005 plain_text_0 / plain_text_1 / plain_text_2 / plain_text_3  input  32 each  plaintext block.
- Concatenation {plain_text_3,...,plain_text_0} forms the 128-bit block P.
REQ-006 cipher_text_0 / cipher_text_1 / cipher_text_2 / cipher_text_3  output  32 each  ciphertext, same packing as P.
- Registered outputs.
REQ-007 The block SHALL have no handshake ports; operation is free-running.

Function
REQ-008 Byte order: FIPS-197 byte i of key, plaintext and ciphertext SHALL be bus bits [8i+7:8i].
- Byte 0 is the least significant byte of key_0 / plain_text_0 / cipher_text_0.
- State column c = bytes 4c..4c+3.
REQ-009 The block SHALL compute FIPS-197 AES-128 encryption (10 rounds) of P under K.
REQ-010 The design SHALL be iterative, one round per clock, with a two-state FSM.
REQ-011 LOAD state (1 cycle):
- latch K and P;
- state <= P xor K;
- round key <= K;
- rcon <= 0x01;
- round counter <= 1;
- go to ROUND.
REQ-012 ROUND state (10 cycles):
- each cycle apply SubBytes, ShiftRows, MixColumns and AddRoundKey;
- the round key is expanded on the fly from the previous round key and rcon, and that register is updated;
- rcon advances by xtime (01,02,04,...,80,1B,36);
- round counter increments.
REQ-013 Round 10 SHALL omit MixColumns.
REQ-014 On the round-10 cycle, the result SHALL be written to cipher_text_0..3, and the FSM SHALL return to LOAD.
REQ-015 Result period: one new result every 11 cycles.
REQ-016 Outputs SHALL hold their value between updates.
REQ-017 Input change timing:
- Inputs SHALL be sampled only in LOAD.
- Changes during ROUND SHALL NOT affect the computation in flight.
- A changed input SHALL be reflected on the outputs no later than 22 cycles after the change.
REQ-018 Unchanged inputs SHALL produce the identical ciphertext on every iteration; no glitch or intermediate value is visible on the outputs.
REQ-019 S-box: standard FIPS-197 forward S-box, implemented combinationally as lookup.
- 16 instances for the state, 4 for the key schedule.
REQ-020 MixColumns SHALL use the GF(2^8) polynomial x^8+x^4+x^3+x+1.

Reset
REQ-021 While reset is high:
- FSM = LOAD;
- round counter = 0 (cleared, then set to 1 by the next LOAD);
- state, round key and rcon registers = 0;
- cipher_text_0..3 = 32'h0.
REQ-022 Reset asserted mid-computation SHALL abort it immediately; outputs return to 0.
REQ-023 After reset deasserts:
- the first rising edge performs LOAD;
- the first valid ciphertext appears on the 11th rising edge after deassertion.

Verification
REQ-024 FIPS-197 App. C.1:
- key 0x0f0e0d0c0b0a09080706050403020100, pt 0xffeeddccbbaa99887766554433221100;
- required cipher 0x5ac5b47080b7cdd830047b6ad8e0c469 by edge 11 after reset release.
REQ-025 FIPS-197 App. B:
- key 0x3c4fcf098815f7aba6d2ae2816157e2b, pt 0x340737e0a29831318d305a88a8f64332;
- required cipher 0x320b6a19978511dcfb09dc021d842539.
REQ-026 Reset value:
- assert reset with any inputs -> all cipher_text words 0;
- the C.1 result appears 11 edges after release.
REQ-027 Input change:
- switch from the C.1 vector to the App. B vector mid-ROUND;
- the next update still shows the C.1 result;
- the App. B result appears within 22 cycles and stays stable for 4000 cycles.
REQ-028 Mid-operation reset:
- pulse reset during round 5 -> outputs 0 at once;
- the correct result appears 11 edges after release.
REQ-029 Stability:
- hold key 0x100F0E0D0C0B0A090807060504030201, pt 0x54494d47206e616c6f4e20726f6e6f43 for 4000 cycles;
- cipher_text equals the software reference model (same byte order) and never changes after first valid.

Source files
------------

// File: rtl/aes128_encrypt_top.sv
// Iterative AES-128 encryption core: one LOAD cycle then ten round cycles,
// key schedule expanded on the fly alongside the state.
module aes128_encrypt_top (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] key_0,
    input  logic [31:0] key_1,
    input  logic [31:0] key_2,
    input  logic [31:0] key_3,
    input  logic [31:0] plain_text_0,
    input  logic [31:0] plain_text_1,
    input  logic [31:0] plain_text_2,
    input  logic [31:0] plain_text_3,
    output logic [31:0] cipher_text_0,
    output logic [31:0] cipher_text_1,
    output logic [31:0] cipher_text_2,
    output logic [31:0] cipher_text_3
);

    localparam logic [0:0] ST_LOAD  = 1'b0;
    localparam logic [0:0] ST_ROUND = 1'b1;

    // Forward S-box, entry 0x00 in the most significant byte.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    logic [0:0]   r_fsm;
    logic [3:0]   r_round;
    logic [127:0] r_state;
    logic [127:0] r_rkey;
    logic [7:0]   r_rcon;
    logic [127:0] r_ct;

    logic [127:0] w_key;
    logic [127:0] w_pt;
    logic [127:0] w_sr;
    logic [127:0] w_mc;
    logic [127:0] w_next_rkey;
    logic [127:0] w_round_out;

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX_TABLE[{~x, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    // Output byte (row r, column c) comes from input column (c + r) mod 4.
    function automatic logic [127:0] sub_shift(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[8*(4*c+r) +: 8] = sbox(s[8*(4*((c+r)%4)+r) +: 8]);
            end
        end
        return o;
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] a);
        logic [7:0] a0, a1, a2, a3, b0, b1, b2, b3;
        a0 = a[7:0];
        a1 = a[15:8];
        a2 = a[23:16];
        a3 = a[31:24];
        b0 = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
        b1 = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
        b2 = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
        b3 = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        return {b3, b2, b1, b0};
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        return {mix_col(s[127:96]), mix_col(s[95:64]), mix_col(s[63:32]), mix_col(s[31:0])};
    endfunction

    // RotWord/SubWord/Rcon on the last word, byte 0 held in bits [7:0].
    function automatic logic [127:0] key_expand(input logic [127:0] rk, input logic [7:0] rc);
        logic [31:0] t, n0, n1, n2, n3;
        t  = {sbox(rk[103:96]), sbox(rk[127:120]), sbox(rk[119:112]), sbox(rk[111:104]) ^ rc};
        n0 = rk[31:0] ^ t;
        n1 = rk[63:32] ^ n0;
        n2 = rk[95:64] ^ n1;
        n3 = rk[127:96] ^ n2;
        return {n3, n2, n1, n0};
    endfunction

    assign w_key       = {key_3, key_2, key_1, key_0};
    assign w_pt        = {plain_text_3, plain_text_2, plain_text_1, plain_text_0};
    assign w_sr        = sub_shift(r_state);
    assign w_mc        = mix_columns(w_sr);
    assign w_next_rkey = key_expand(r_rkey, r_rcon);
    assign w_round_out = ((r_round == 4'd10) ? w_sr : w_mc) ^ w_next_rkey;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fsm   <= ST_LOAD;
            r_round <= 4'd0;
            r_state <= '0;
            r_rkey  <= '0;
            r_rcon  <= 8'h00;
            r_ct    <= '0;
        end else begin
            case (r_fsm)
                ST_LOAD: begin
                    r_state <= w_pt ^ w_key;
                    r_rkey  <= w_key;
                    r_rcon  <= 8'h01;
                    r_round <= 4'd1;
                    r_fsm   <= ST_ROUND;
                end
                default: begin
                    r_state <= w_round_out;
                    r_rkey  <= w_next_rkey;
                    r_rcon  <= xtime(r_rcon);
                    r_round <= r_round + 4'd1;
                    if (r_round == 4'd10) begin
                        r_ct  <= w_round_out;
                        r_fsm <= ST_LOAD;
                    end
                end
            endcase
        end
    end

    assign cipher_text_0 = r_ct[31:0];
    assign cipher_text_1 = r_ct[63:32];
    assign cipher_text_2 = r_ct[95:64];
    assign cipher_text_3 = r_ct[127:96];

endmodule

// File: tb/tb_aes128_encrypt_top.sv
// Randomized and known-answer bench for aes128_encrypt_top against a
// byte-array AES-128 model whose S-box is derived from GF(2^8) arithmetic.
module tb_aes128_encrypt_top;

    logic        clk;
    logic        reset;
    logic [31:0] key_0, key_1, key_2, key_3;
    logic [31:0] plain_text_0, plain_text_1, plain_text_2, plain_text_3;
    logic [31:0] cipher_text_0, cipher_text_1, cipher_text_2, cipher_text_3;

    int n_checks;
    int n_errors;

    logic [7:0] sbox_t [256];

    localparam logic [127:0] C1_KEY = 128'h0f0e0d0c0b0a09080706050403020100;
    localparam logic [127:0] C1_PT  = 128'hffeeddccbbaa99887766554433221100;
    localparam logic [127:0] C1_CT  = 128'h5ac5b47080b7cdd830047b6ad8e0c469;
    localparam logic [127:0] B_KEY  = 128'h3c4fcf098815f7aba6d2ae2816157e2b;
    localparam logic [127:0] B_PT   = 128'h340737e0a29831318d305a88a8f64332;
    localparam logic [127:0] B_CT   = 128'h320b6a19978511dcfb09dc021d842539;
    localparam logic [127:0] S_KEY  = 128'h100F0E0D0C0B0A090807060504030201;
    localparam logic [127:0] S_PT   = 128'h54494d47206e616c6f4e20726f6e6f43;

    aes128_encrypt_top dut (
        .clk           (clk),
        .reset         (reset),
        .key_0         (key_0),
        .key_1         (key_1),
        .key_2         (key_2),
        .key_3         (key_3),
        .plain_text_0  (plain_text_0),
        .plain_text_1  (plain_text_1),
        .plain_text_2  (plain_text_2),
        .plain_text_3  (plain_text_3),
        .cipher_text_0 (cipher_text_0),
        .cipher_text_1 (cipher_text_1),
        .cipher_text_2 (cipher_text_2),
        .cipher_text_3 (cipher_text_3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [127:0] ct_now();
        return {cipher_text_3, cipher_text_2, cipher_text_1, cipher_text_0};
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa, bb;
        p  = 8'h00;
        aa = a;
        bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
            bb = bb >> 1;
        end
        return p;
    endfunction

    // S-box = affine transform of the multiplicative inverse.
    task automatic build_sbox();
        logic [7:0] inv, b, c;
        c = 8'h63;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            for (int i = 0; i < 8; i++) begin
                b[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
            end
            sbox_t[x] = b;
        end
    endtask

    function automatic logic [127:0] aes_ref(input logic [127:0] k, input logic [127:0] p);
        logic [7:0] w [176];
        logic [7:0] s [16];
        logic [7:0] t [16];
        logic [7:0] tmp [4];
        logic [7:0] rc, x, a0, a1, a2, a3;
        logic [127:0] o;
        for (int i = 0; i < 16; i++) begin
            w[i] = k[8*i +: 8];
            s[i] = p[8*i +: 8];
        end
        rc = 8'h01;
        for (int i = 16; i < 176; i += 4) begin
            for (int j = 0; j < 4; j++) tmp[j] = w[i-4+j];
            if (i % 16 == 0) begin
                x      = tmp[0];
                tmp[0] = sbox_t[tmp[1]] ^ rc;
                tmp[1] = sbox_t[tmp[2]];
                tmp[2] = sbox_t[tmp[3]];
                tmp[3] = sbox_t[x];
                rc     = gmul(rc, 8'h02);
            end
            for (int j = 0; j < 4; j++) w[i+j] = w[i-16+j] ^ tmp[j];
        end
        for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[i];
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) s[i] = sbox_t[s[i]];
            for (int c = 0; c < 4; c++)
                for (int row = 0; row < 4; row++)
                    t[4*c+row] = s[4*((c+row)%4)+row];
            if (r < 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                    s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
                    s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
                end
            end else begin
                for (int i = 0; i < 16; i++) s[i] = t[i];
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[16*r+i];
        end
        for (int i = 0; i < 16; i++) o[8*i +: 8] = s[i];
        return o;
    endfunction

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic set_in(input logic [127:0] k, input logic [127:0] p);
        {key_3, key_2, key_1, key_0} = k;
        {plain_text_3, plain_text_2, plain_text_1, plain_text_0} = p;
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        logic [127:0] k, p, exp, prev;
        int bad;
        int found;
        n_checks = 0;
        n_errors = 0;
        build_sbox();

        // Reset with arbitrary inputs.
        reset = 1'b1;
        set_in(rnd128(), rnd128());
        ticks(3);
        check_eq("rst_zero", ct_now(), 128'h0);

        // Known answer C.1: valid exactly on the 11th edge after release.
        set_in(C1_KEY, C1_PT);
        reset = 1'b0;
        ticks(10);
        check_eq("c1_edge10", ct_now(), 128'h0);
        tick();
        check_eq("c1_edge11", ct_now(), C1_CT);

        // Switch to App. B four edges into the next computation.
        ticks(4);
        set_in(B_KEY, B_PT);
        bad = 0;
        for (int i = 0; i < 7; i++) begin
            tick();
            if (ct_now() !== C1_CT) bad++;
        end
        check_eq("chg_hold_c1", 128'(bad), 128'h0);
        check_eq("chg_next_upd", ct_now(), C1_CT);
        found = 0;
        for (int i = 0; i < 15 && found == 0; i++) begin
            tick();
            if (ct_now() === B_CT) found = 1;
        end
        check_eq("chg_latency", 128'(found), 128'h1);
        check_eq("appb", ct_now(), B_CT);
        bad = 0;
        for (int i = 0; i < 4004; i++) begin
            tick();
            if (ct_now() !== B_CT) bad++;
        end
        check_eq("appb_stable", 128'(bad), 128'h0);

        // Random vectors, changed right after an update edge.
        prev = B_CT;
        for (int v = 0; v < 12; v++) begin
            if (v == 0) begin
                k = '0; p = '0;
            end else if (v == 1) begin
                k = '1; p = '1;
            end else begin
                k = rnd128(); p = rnd128();
            end
            exp = aes_ref(k, p);
            set_in(k, p);
            ticks(10);
            check_eq("rnd_hold", ct_now(), prev);
            tick();
            check_eq("rnd_result", ct_now(), exp);
            prev = exp;
        end

        // Reset pulsed while round 5 is pending.
        k = rnd128(); p = rnd128();
        set_in(k, p);
        ticks(11);
        check_eq("pre_midrst", ct_now(), aes_ref(k, p));
        ticks(5);
        k = rnd128(); p = rnd128();
        set_in(k, p);
        reset = 1'b1;
        #1;
        check_eq("midrst_async_zero", ct_now(), 128'h0);
        ticks(2);
        check_eq("midrst_held_zero", ct_now(), 128'h0);
        reset = 1'b0;
        ticks(10);
        check_eq("midrst_edge10", ct_now(), 128'h0);
        tick();
        check_eq("midrst_edge11", ct_now(), aes_ref(k, p));

        // Long stability run with a fixed vector.
        exp = aes_ref(S_KEY, S_PT);
        set_in(S_KEY, S_PT);
        ticks(11);
        check_eq("stab_first", ct_now(), exp);
        bad = 0;
        for (int i = 0; i < 4004; i++) begin
            tick();
            if (ct_now() !== exp) bad++;
        end
        check_eq("stab_4000", 128'(bad), 128'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
